// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi add-compare-select array.
package viterbi_pkg;

    localparam int PKG_W = 6;
    localparam int PKG_K = 3;

    typedef logic [PKG_K-2:0] state_idx_t;
    typedef logic [PKG_W-1:0] metric_t;

    // Codeword {c0,c1} emitted when the encoder register holds state_reg.
    function automatic logic [1:0] codeword(input logic [31:0] state_reg,
                                            input logic [31:0] g0,
                                            input logic [31:0] g1);
        return {^(state_reg & g0), ^(state_reg & g1)};
    endfunction

    // All-ones value of a w-bit metric, used as the saturation ceiling.
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/viterbi_acs_array_sat_add.sv
// Unsigned saturating adder: W-bit path metric plus BMW-bit branch metric.
module sat_add
    import viterbi_pkg::*;
#(
    parameter int W   = 6,
    parameter int BMW = 3
) (
    input  logic [W-1:0]   a,
    input  logic [BMW-1:0] b,
    output logic [W-1:0]   sum
);

    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));

    logic [W:0] full_s;

    assign full_s = {1'b0, a} + (W+1)'(b);
    assign sum    = full_s[W] ? SAT_MAX : full_s[W-1:0];

endmodule

// File: rtl/viterbi_acs_array.sv
// Registered add-compare-select array with metric normalisation and best-state search.
module viterbi_acs_array
    import viterbi_pkg::*;
#(
    parameter int             W          = 6,
    parameter int             BMW        = 3,
    parameter int             K          = 3,
    parameter logic [K-1:0]   G0         = 3'b111,
    parameter logic [K-1:0]   G1         = 3'b101,
    parameter int             INIT_OTHER = (1 << (W-1)) - 1,
    localparam int            NS         = 1 << (K-1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [4*BMW-1:0]  bm,
    output logic              out_valid,
    output logic [NS-1:0]     dec,
    output logic [K-2:0]      best_state,
    output logic              norm,
    output logic [NS*W-1:0]   pm,
    output logic [15:0]       step_count
);

    localparam logic [W-1:0] INIT_M = W'(INIT_OTHER);

    logic [W-1:0]  pm_r        [NS];
    logic [W-1:0]  init_pm_s   [NS];
    logic [W-1:0]  base_pm_s   [NS];
    logic [W-1:0]  cand0_s     [NS];
    logic [W-1:0]  cand1_s     [NS];
    logic [W-1:0]  new_pm_s    [NS];
    logic [W-1:0]  norm_pm_s   [NS];
    logic [NS-1:0] dec_s;
    logic [NS-1:0] msb_s;
    logic          all_msb_s;
    logic [W-1:0]  min_val_s;
    logic [K-2:0]  best_s;

    // Initial metrics and the metrics a step starts from (start reloads them first).
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            init_pm_s[s] = (s == 0) ? '0 : INIT_M;
            base_pm_s[s] = start ? init_pm_s[s] : pm_r[s];
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_acs
        localparam int P0  = 2 * (s % (NS/2));
        localparam int U   = (s >> (K-2)) & 1;
        localparam int CW0 = int'(codeword(32'((U << (K-1)) | P0),     32'(G0), 32'(G1)));
        localparam int CW1 = int'(codeword(32'((U << (K-1)) | (P0+1)), 32'(G0), 32'(G1)));

        sat_add #(.W(W), .BMW(BMW)) u_add0 (
            .a   (base_pm_s[P0]),
            .b   (bm[CW0*BMW +: BMW]),
            .sum (cand0_s[s])
        );

        sat_add #(.W(W), .BMW(BMW)) u_add1 (
            .a   (base_pm_s[P0+1]),
            .b   (bm[CW1*BMW +: BMW]),
            .sum (cand1_s[s])
        );

        // Strict compare so the even predecessor wins ties.
        assign dec_s[s]     = (cand1_s[s] < cand0_s[s]);
        assign new_pm_s[s]  = dec_s[s] ? cand1_s[s] : cand0_s[s];
        assign msb_s[s]     = new_pm_s[s][W-1];
        assign norm_pm_s[s] = all_msb_s ? {1'b0, new_pm_s[s][W-2:0]} : new_pm_s[s];
        assign pm[s*W +: W] = pm_r[s];
    end

    assign all_msb_s = &msb_s;

    // Minimum search over normalised metrics; lowest index kept on ties.
    always_comb begin
        min_val_s = norm_pm_s[0];
        best_s    = '0;
        for (int s = 1; s < NS; s++) begin
            best_s    = (norm_pm_s[s] < min_val_s) ? (K-1)'(s) : best_s;
            min_val_s = (norm_pm_s[s] < min_val_s) ? norm_pm_s[s] : min_val_s;
        end
    end

    // Metric, decision and step-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) pm_r[s] <= init_pm_s[s];
            step_count <= 16'd0;
            out_valid  <= 1'b0;
            dec        <= '0;
            best_state <= '0;
            norm       <= 1'b0;
        end else if (in_valid) begin
            for (int s = 0; s < NS; s++) pm_r[s] <= norm_pm_s[s];
            if (start) begin
                step_count <= 16'd1;
            end else begin
                step_count <= (step_count == 16'hFFFF) ? 16'hFFFF : step_count + 16'd1;
            end
            out_valid  <= 1'b1;
            dec        <= dec_s;
            best_state <= best_s;
            norm       <= all_msb_s;
        end else if (start) begin
            for (int s = 0; s < NS; s++) pm_r[s] <= init_pm_s[s];
            step_count <= 16'd0;
            out_valid  <= 1'b0;
            dec        <= '0;
            best_state <= '0;
            norm       <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_acs_array.sv
// Directed and randomised checks of viterbi_acs_array against a behavioural trellis model.
module tb_viterbi_acs_array;

    localparam int W   = 6;
    localparam int BMW = 3;
    localparam int K   = 3;
    localparam int NS  = 4;
    localparam int G0  = 7;
    localparam int G1  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [4*BMW-1:0]  bm;

    logic              out_valid;
    logic [NS-1:0]     dec;
    logic [K-2:0]      best_state;
    logic              norm;
    logic [NS*W-1:0]   pm;
    logic [15:0]       step_count;

    logic              s_out_valid;
    logic [NS-1:0]     s_dec;
    logic [K-2:0]      s_best_state;
    logic              s_norm;
    logic [NS*4-1:0]   s_pm;
    logic [15:0]       s_step_count;

    int errors = 0;
    int checks = 0;

    int m_pm [NS];
    int m_dec;
    int m_best;
    int m_norm;
    int m_cnt;

    always #5 clk = ~clk;

    viterbi_acs_array dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .bm         (bm),
        .out_valid  (out_valid),
        .dec        (dec),
        .best_state (best_state),
        .norm       (norm),
        .pm         (pm),
        .step_count (step_count)
    );

    viterbi_acs_array #(.W(4), .INIT_OTHER(15)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .bm         (bm),
        .out_valid  (s_out_valid),
        .dec        (s_dec),
        .best_state (s_best_state),
        .norm       (s_norm),
        .pm         (s_pm),
        .step_count (s_step_count)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] pack_pm(input int a, input int b, input int c, input int d);
        return {d[5:0], c[5:0], b[5:0], a[5:0]};
    endfunction

    function automatic int parity(input int v);
        int p = 0;
        for (int i = 0; i < 32; i++) p = p ^ ((v >> i) & 1);
        return p;
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int s = 1; s < NS; s++) m_pm[s] = 31;
        m_cnt  = 0;
        m_dec  = 0;
        m_best = 0;
        m_norm = 0;
    endtask

    task automatic model_step(input logic [11:0] bmv);
        int np [NS];
        int half;
        int all_hi;
        half   = NS / 2;
        m_dec  = 0;
        all_hi = 1;
        for (int s = 0; s < NS; s++) begin
            int win;
            win = 0;
            for (int j = 0; j < 2; j++) begin
                int p;
                int r;
                int idx;
                int c;
                p   = 2 * (s % half) + j;
                r   = (s / half) * NS + p;
                idx = parity(r & G0) * 2 + parity(r & G1);
                c   = m_pm[p] + int'((bmv >> (idx * 3)) & 12'd7);
                if (c > 63) c = 63;
                if (j == 0) begin
                    win = c;
                end else if (c < win) begin
                    win   = c;
                    m_dec = m_dec | (1 << s);
                end
            end
            np[s] = win;
            if (win < 32) all_hi = 0;
        end
        m_norm = all_hi;
        m_best = 0;
        for (int s = 0; s < NS; s++) begin
            m_pm[s] = all_hi ? np[s] - 32 : np[s];
            if (m_pm[s] < m_pm[m_best]) m_best = s;
        end
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    endtask

    task automatic check_all(input string tag, input logic exp_valid);
        check({tag, ".out_valid"},  out_valid,  exp_valid);
        check({tag, ".pm"},         pm,         pack_pm(m_pm[0], m_pm[1], m_pm[2], m_pm[3]));
        check({tag, ".dec"},        dec,        m_dec[3:0]);
        check({tag, ".best_state"}, best_state, m_best[1:0]);
        check({tag, ".norm"},       norm,       m_norm[0]);
        check({tag, ".step_count"}, step_count, m_cnt[15:0]);
    endtask

    task automatic tick(input logic r, input logic s, input logic v, input logic [11:0] b);
        reset    = r;
        start    = s;
        in_valid = v;
        bm       = b;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] b;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        bm       = 12'd0;

        tick(1'b1, 1'b0, 1'b0, 12'd0);
        tick(1'b1, 1'b0, 1'b0, 12'd0);
        model_reset();
        check_all("reset", 1'b0);
        check("reset.small_pm", s_pm, 16'hFFF0);

        tick(1'b0, 1'b0, 1'b1, 12'd0);
        model_step(12'd0);
        check_all("bm0", 1'b1);
        check("bm0.pm_const", pm, pack_pm(0, 31, 0, 31));
        tick(1'b0, 1'b0, 1'b0, 12'd0);
        check_all("bm0.hold", 1'b0);

        tick(1'b1, 1'b0, 1'b0, 12'd0);
        model_reset();
        for (int n = 1; n <= 6; n++) begin
            tick(1'b0, 1'b0, 1'b1, 12'hFFF);
            model_step(12'hFFF);
            check_all("bm7", 1'b1);
            if (n == 1) begin
                check("bm7.step1_pm", pm, pack_pm(7, 38, 7, 38));
                check("small.pm",     s_pm, 16'hF7F7);
                check("small.dec",    s_dec, 4'd0);
                check("small.best",   s_best_state, 2'd0);
                check("small.norm",   s_norm, 1'b0);
                check("small.valid",  s_out_valid, 1'b1);
                check("small.count",  s_step_count, 16'd1);
            end
            if (n == 5) begin
                check("bm7.step5_pm", pm, pack_pm(3, 3, 3, 3));
                check("bm7.step5_norm", norm, 1'b1);
            end
            if (n == 6) check("bm7.step6_norm", norm, 1'b0);
        end

        tick(1'b1, 1'b0, 1'b0, 12'd0);
        model_reset();
        tick(1'b0, 1'b0, 1'b1, 12'hFF8);
        model_step(12'hFF8);
        check_all("golden0", 1'b1);
        for (int n = 0; n < 19; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b0, 1'b0, 1'b0, 12'd0);
                check_all("rand.idle", 1'b0);
            end
            b = 12'($urandom);
            tick(1'b0, 1'b0, 1'b1, b);
            model_step(b);
            check_all("rand", 1'b1);
        end

        b = 12'($urandom);
        model_reset();
        model_step(b);
        tick(1'b0, 1'b1, 1'b1, b);
        check_all("start_valid", 1'b1);
        check("start_valid.count", step_count, 16'd1);

        b = 12'($urandom);
        tick(1'b0, 1'b0, 1'b1, b);
        model_step(b);
        check_all("pre_start", 1'b1);
        tick(1'b0, 1'b1, 1'b0, 12'd0);
        model_reset();
        check_all("start_only", 1'b0);

        b = 12'($urandom);
        tick(1'b0, 1'b0, 1'b1, b);
        model_step(b);
        check_all("pre_reset", 1'b1);
        tick(1'b1, 1'b0, 1'b1, 12'($urandom));
        model_reset();
        check_all("reset_valid", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
